// File: rtl/sdram_port_pkg.sv
// Shared types and default sizes for the buffered SDRAM responder port.
package sdram_port_pkg;

   localparam int ADDR_W_DEF   = 25;
   localparam int DATA_W_DEF   = 16;
   localparam int CNT_W_DEF    = 16;
   localparam int DEPTH_LG_DEF = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_REQ  = 2'd1,
      RD_REQ  = 2'd2,
      RD_WAIT = 2'd3
   } port_state_t;

   // True while a read transaction is in flight (requested or awaiting data).
   function automatic logic is_rd_state(input port_state_t s);
      return (s == RD_REQ) || (s == RD_WAIT);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush. head_o shows the oldest word
// whenever the FIFO is non-empty; count, full and empty are registered.
module sync_fifo #(
   parameter int DATA_W   = 16,
   parameter int DEPTH_LG = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush_i,
   input  logic                push_i,
   input  logic                pop_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   head_o,
   output logic [DEPTH_LG:0]   count_o,
   output logic                full_o,
   output logic                empty_o
);

   localparam int DEPTH = 2 ** DEPTH_LG;
   localparam logic [DEPTH_LG:0] DEPTH_CNT = (DEPTH_LG + 1)'(DEPTH);

   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DEPTH_LG-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LG-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LG:0]   count_q, count_d;
   logic                do_push;
   logic                do_pop;

   assign full_o  = (count_q == DEPTH_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO or a pop from an empty one is simply ignored.
   assign do_push = push_i & ~full_o  & ~flush_i;
   assign do_pop  = pop_i  & ~empty_o & ~flush_i;

   // Pointer and occupancy next-state; flush wins over everything.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LG'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LG'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (DEPTH_LG + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LG + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/sdram_fifo_port.sv
// Buffered SDRAM responder port: client writes are queued and drained to
// memory at an auto-incrementing address, reads are prefetched into a FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction outstanding; writes take priority over reads
// WR_REQ  | write request held on the memory port until mem_ack
// RD_REQ  | read request held on the memory port until mem_ack
// RD_WAIT | read accepted, waiting for mem_rvalid
module sdram_fifo_port
   import sdram_port_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DEPTH_LG = DEPTH_LG_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write_ld,
   input  logic [ADDR_W-1:0] writeaddr,
   input  logic              write_req,
   input  logic [DATA_W-1:0] writedata,
   input  logic              read_ld,
   input  logic [ADDR_W-1:0] readaddr,
   input  logic              read_req,
   output logic [DATA_W-1:0] readdata,
   output logic [CNT_W-1:0]  wr_buffer,
   output logic [CNT_W-1:0]  rd_buffer,
   output logic              wr_overflow,
   output logic              rd_underflow,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);

   port_state_t state_q, state_d;

   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] readdata_q, readdata_d;
   logic              wr_overflow_q, wr_overflow_d;
   logic              rd_underflow_q, rd_underflow_d;
   logic              prefetch_en_q, prefetch_en_d;
   logic              wr_stale_q, wr_stale_d;
   logic              rd_stale_q, rd_stale_d;

   logic              wf_push, wf_pop, wf_full, wf_empty;
   logic [DATA_W-1:0] wf_head;
   logic [DEPTH_LG:0] wf_count;
   logic              rf_push, rf_pop, rf_full, rf_empty;
   logic [DATA_W-1:0] rf_head;
   logic [DEPTH_LG:0] rf_count;

   logic              start_wr, start_rd;
   logic              wr_done, wr_commit;
   logic              rd_done, rd_commit;

   sync_fifo #(.DATA_W(DATA_W), .DEPTH_LG(DEPTH_LG)) u_wr_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (write_ld),
      .push_i  (wf_push),
      .pop_i   (wf_pop),
      .wdata_i (writedata),
      .head_o  (wf_head),
      .count_o (wf_count),
      .full_o  (wf_full),
      .empty_o (wf_empty)
   );

   sync_fifo #(.DATA_W(DATA_W), .DEPTH_LG(DEPTH_LG)) u_rd_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (read_ld),
      .push_i  (rf_push),
      .pop_i   (rf_pop),
      .wdata_i (mem_rdata),
      .head_o  (rf_head),
      .count_o (rf_count),
      .full_o  (rf_full),
      .empty_o (rf_empty)
   );

   // A load in the same cycle suppresses starting a transaction from stale
   // FIFO/address contents; the next IDLE cycle sees the reloaded state.
   assign start_wr = ~wf_empty & ~write_ld;
   assign start_rd = wf_empty & prefetch_en_q & ~rf_full & ~read_ld;

   // A completion only commits (pop/push, address increment) when no load
   // landed while the transaction was in flight or in the completing cycle.
   assign wr_done   = (state_q == WR_REQ) & mem_ack;
   assign wr_commit = wr_done & ~wr_stale_q & ~write_ld;
   assign rd_done   = ((state_q == RD_WAIT) & mem_rvalid) |
                      ((state_q == RD_REQ) & mem_ack & mem_rvalid);
   assign rd_commit = rd_done & ~rd_stale_q & ~read_ld;

   assign wf_push = write_req & ~write_ld;
   assign wf_pop  = wr_commit;
   assign rf_push = rd_commit;
   assign rf_pop  = read_req & ~read_ld;

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state; a read whose ack and rvalid coincide skips RD_WAIT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_wr)      state_d = WR_REQ;
            else if (start_rd) state_d = RD_REQ;
         end
         WR_REQ:  if (mem_ack)    state_d = IDLE;
         RD_REQ:  if (mem_ack)    state_d = mem_rvalid ? IDLE : RD_WAIT;
         RD_WAIT: if (mem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: request strobes decoded from the state register.
   always_comb begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         WR_REQ: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
         end
         RD_REQ:  mem_req = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: address counters, latched request, status flags.
   always_comb begin
      wr_addr_d      = wr_addr_q;
      rd_addr_d      = rd_addr_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      readdata_d     = readdata_q;
      prefetch_en_d  = prefetch_en_q | read_ld;

      if (write_ld)       wr_addr_d = writeaddr;
      else if (wr_commit) wr_addr_d = wr_addr_q + ADDR_W'(1);

      if (read_ld)        rd_addr_d = readaddr;
      else if (rd_commit) rd_addr_d = rd_addr_q + ADDR_W'(1);

      // Address and data are captured on entry so a later load cannot
      // disturb a request already presented to the controller.
      if (state_q == IDLE) begin
         if (start_wr) begin
            mem_addr_d  = wr_addr_q;
            mem_wdata_d = wf_head;
         end else if (start_rd) begin
            mem_addr_d  = rd_addr_q;
         end
      end

      if (rf_pop & ~rf_empty) readdata_d = rf_head;

      wr_overflow_d  = write_ld ? 1'b0 : (wr_overflow_q  | (write_req & wf_full));
      rd_underflow_d = read_ld  ? 1'b0 : (rd_underflow_q | (read_req  & rf_empty));

      wr_stale_d = (state_q == WR_REQ) & ~mem_ack & (wr_stale_q | write_ld);
      rd_stale_d = is_rd_state(state_q) & ~rd_done & (rd_stale_q | read_ld);
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_addr_q      <= '0;
         rd_addr_q      <= '0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= '0;
         readdata_q     <= '0;
         wr_overflow_q  <= 1'b0;
         rd_underflow_q <= 1'b0;
         prefetch_en_q  <= 1'b0;
         wr_stale_q     <= 1'b0;
         rd_stale_q     <= 1'b0;
      end else begin
         wr_addr_q      <= wr_addr_d;
         rd_addr_q      <= rd_addr_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         readdata_q     <= readdata_d;
         wr_overflow_q  <= wr_overflow_d;
         rd_underflow_q <= rd_underflow_d;
         prefetch_en_q  <= prefetch_en_d;
         wr_stale_q     <= wr_stale_d;
         rd_stale_q     <= rd_stale_d;
      end
   end

   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign readdata     = readdata_q;
   assign wr_overflow  = wr_overflow_q;
   assign rd_underflow = rd_underflow_q;
   assign wr_buffer    = CNT_W'(wf_count);
   assign rd_buffer    = CNT_W'(rf_count);

endmodule
